// File: rtl/digiota_scan_ctrl_if.sv
// Control and result handshake bundle for the digital OTA scan sequencer.
// master: scan requester / result consumer; slave: the sequencer.
interface digiota_scan_ctrl_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 5
);
  logic             start;
  logic             abort;
  logic [NCH-1:0]   ch_mask;
  logic             busy;
  logic             done;
  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [CNT_W-1:0] res_count;
  logic             res_bit;

  modport master (
    output start, abort, ch_mask, res_ready,
    input  busy, done, res_valid, res_ch, res_count, res_bit
  );

  modport slave (
    input  start, abort, ch_mask, res_ready,
    output busy, done, res_valid, res_ch, res_count, res_bit
  );
endinterface

// File: rtl/digiota_scan_ctrl.sv
// Time-shares one OTA/comparator across NCH channels: select, settle, count
// comparator-high samples, and hand each result out over valid/ready.
module digiota_scan_ctrl #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned NSAMP  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmp_in,
  output logic [CH_W-1:0] ch_sel,
  output logic            ota_en,
  digiota_scan_ctrl_if.slave bus
);

  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT
  } state_t;

  state_t           state;
  logic [NCH-1:0]   scan_mask;
  logic [TMR_W-1:0] settle_cnt;
  logic [TMR_W-1:0] samp_cnt;
  logic [CNT_W-1:0] acc;
  logic             sync1;
  logic             sync2;

  logic [CNT_W-1:0] acc_final_c;
  logic             maj_c;
  logic [NCH-1:0]   mask_rem_c;

  // Lowest set bit gives ascending scan order.
  function automatic logic [CH_W-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (m[i]) lowest = CH_W'(i);
    end
  endfunction

  always_comb begin
    acc_final_c = acc + CNT_W'(sync2);
    maj_c       = {acc_final_c, 1'b0} > (CNT_W + 1)'(NSAMP);
    mask_rem_c  = scan_mask & ~(NCH'(1) << ch_sel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      scan_mask     <= '0;
      settle_cnt    <= '0;
      samp_cnt      <= '0;
      acc           <= '0;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      ch_sel        <= '0;
      ota_en        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_ch    <= '0;
      bus.res_count <= '0;
      bus.res_bit   <= 1'b0;
    end else begin
      sync1    <= cmp_in;
      sync2    <= sync1;
      bus.done <= 1'b0;
      // Abort wins over start and over a handshake in the same cycle.
      if (bus.abort && state != ST_IDLE) begin
        state         <= ST_IDLE;
        scan_mask     <= '0;
        ota_en        <= 1'b0;
        bus.busy      <= 1'b0;
        bus.res_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start && !bus.abort) begin
              if (bus.ch_mask != '0) begin
                scan_mask  <= bus.ch_mask;
                ch_sel     <= lowest(bus.ch_mask);
                settle_cnt <= TMR_W'(SETTLE - 1);
                ota_en     <= 1'b1;
                bus.busy   <= 1'b1;
                state      <= ST_SETTLE;
              end else begin
                bus.done <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == '0) begin
              acc      <= '0;
              samp_cnt <= '0;
              state    <= ST_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - TMR_W'(1);
            end
          end
          ST_SAMPLE: begin
            acc      <= acc_final_c;
            samp_cnt <= samp_cnt + TMR_W'(1);
            if (samp_cnt == TMR_W'(NSAMP - 1)) begin
              bus.res_count <= acc_final_c;
              bus.res_ch    <= ch_sel;
              bus.res_bit   <= maj_c;
              bus.res_valid <= 1'b1;
              ota_en        <= 1'b0;
              state         <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            if (bus.res_ready) begin
              bus.res_valid <= 1'b0;
              scan_mask     <= mask_rem_c;
              if (mask_rem_c != '0) begin
                ch_sel     <= lowest(mask_rem_c);
                settle_cnt <= TMR_W'(SETTLE - 1);
                ota_en     <= 1'b1;
                state      <= ST_SETTLE;
              end else begin
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                state    <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digiota_scan_ctrl.sv
// Scoreboard bench for digiota_scan_ctrl: expected per-channel results are
// queued at stimulus time and compared as each result is handed off.
module tb_digiota_scan_ctrl;
  localparam int unsigned NCH    = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned NSAMP  = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int LAT = SETTLE + NSAMP;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmp_in = 1'b0;
  logic [CH_W-1:0] ch_sel;
  logic            ota_en;

  digiota_scan_ctrl_if #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  digiota_scan_ctrl #(
    .NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE), .NSAMP(NSAMP), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmp_in (cmp_in),
    .ch_sel (ch_sel),
    .ota_en (ota_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] cnt;
    logic             maj;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   mode[NCH];   // 0: comparator low, 1: high, 2: toggling

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [NCH-1:0] m);
    bus.ch_mask = m;
    bus.start   = 1'b1;
    tick(1);
    bus.start   = 1'b0;
  endtask

  task automatic push_scan(input logic [NCH-1:0] m);
    res_t e;
    for (int i = 0; i < int'(NCH); i++) begin
      if (m[i]) begin
        e.ch  = CH_W'(i);
        e.cnt = (mode[i] == 0) ? CNT_W'(0) :
                (mode[i] == 1) ? CNT_W'(NSAMP) : CNT_W'(NSAMP / 2);
        e.maj = (2 * int'(e.cnt)) > int'(NSAMP);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int c;
    c = 0;
    while (!bus.done && c < bound) begin
      tick(1);
      c++;
    end
    check(tag, int'(bus.done), 1);
  endtask

  task automatic wait_valid(input int bound, output int lat, output int ota_n);
    lat = 0;
    ota_n = 0;
    while (!bus.res_valid && lat < bound) begin
      if (ota_en) ota_n++;
      tick(1);
      lat++;
    end
  endtask

  // Comparator stimulus follows the currently selected channel.
  initial forever begin
    @(negedge clk);
    case (mode[ch_sel])
      0:       cmp_in = 1'b0;
      1:       cmp_in = 1'b1;
      default: cmp_in = ~cmp_in;
    endcase
  end

  // Result monitor: pops the scoreboard on every handshake.
  initial forever begin
    res_t e;
    @(negedge clk);
    #1;
    if (bus.done) done_cnt++;
    if (bus.res_valid && bus.res_ready && rst_n && !bus.abort) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("res_ch", int'(bus.res_ch), int'(e.ch));
        check("res_count", int'(bus.res_count), int'(e.cnt));
        check("res_bit", int'(bus.res_bit), int'(e.maj));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ota_n, d0;
    bit h_valid, h_ch, h_cnt, h_ota, h_sel;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ch_mask = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < int'(NCH); i++) mode[i] = 0;

    // Reset values
    rst_n = 1'b0;
    tick(3);
    check("rst_ch_sel", int'(ch_sel), 0);
    check("rst_ota_en", int'(ota_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of SAMPLE
    mode[0] = 1;
    bus.res_ready = 1'b1;
    do_start(4'b0001);
    tick(12);
    rst_n = 1'b0;
    tick(2);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ota", int'(ota_en), 0);
    check("midrst_valid", int'(bus.res_valid), 0);
    check("midrst_ch_sel", int'(ch_sel), 0);
    rst_n = 1'b1;
    d0 = done_cnt;
    tick(40);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", int'(bus.busy), 0);

    // Single channel, latency and OTA enable window
    mode[0] = 0;
    mode[2] = 1;
    push_scan(4'b0100);
    do_start(4'b0100);
    check("single_ch_sel", int'(ch_sel), 2);
    check("single_busy", int'(bus.busy), 1);
    wait_valid(100, lat, ota_n);
    check("single_latency", lat, LAT);
    check("single_ota_cycles", ota_n, LAT);
    check("single_no_early_done", int'(bus.done), 0);
    tick(1);
    check("single_done", int'(bus.done), 1);
    check("single_busy_end", int'(bus.busy), 0);
    tick(1);
    check("single_done_pulse", int'(bus.done), 0);
    check("single_q_empty", exp_q.size(), 0);

    // Multi-channel scan in ascending order
    mode[0] = 0;
    mode[1] = 2;
    mode[2] = 0;
    mode[3] = 1;
    d0 = done_cnt;
    push_scan(4'b1011);
    do_start(4'b1011);
    wait_done("multi_done_seen", 300);
    tick(5);
    check("multi_done_count", done_cnt - d0, 1);
    check("multi_q_empty", exp_q.size(), 0);

    // Backpressure holds the result
    mode[0] = 1;
    mode[1] = 0;
    bus.res_ready = 1'b0;
    push_scan(4'b0011);
    do_start(4'b0011);
    wait_valid(100, lat, ota_n);
    check("bp_latency", lat, LAT);
    h_valid = 1; h_ch = 1; h_cnt = 1; h_ota = 1; h_sel = 1;
    for (int i = 0; i < 10; i++) begin
      if (!bus.res_valid) h_valid = 0;
      if (bus.res_ch != '0) h_ch = 0;
      if (bus.res_count != CNT_W'(NSAMP)) h_cnt = 0;
      if (ota_en) h_ota = 0;
      if (ch_sel != '0) h_sel = 0;
      tick(1);
    end
    check("bp_hold_valid", int'(h_valid), 1);
    check("bp_hold_res_ch", int'(h_ch), 1);
    check("bp_hold_count", int'(h_cnt), 1);
    check("bp_ota_low", int'(h_ota), 1);
    check("bp_ch_sel_hold", int'(h_sel), 1);
    bus.res_ready = 1'b1;
    tick(1);
    check("bp_next_ota", int'(ota_en), 1);
    check("bp_next_ch_sel", int'(ch_sel), 1);
    check("bp_next_valid", int'(bus.res_valid), 0);
    wait_done("bp_done_seen", 200);
    tick(2);
    check("bp_q_empty", exp_q.size(), 0);

    // Abort during SETTLE
    mode[0] = 1;
    d0 = done_cnt;
    do_start(4'b0001);
    tick(3);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_ota", int'(ota_en), 0);
    check("abort_valid", int'(bus.res_valid), 0);
    tick(40);
    check("abort_no_done", done_cnt - d0, 0);

    // Start while busy is ignored
    mode[1] = 1;
    d0 = done_cnt;
    push_scan(4'b0010);
    do_start(4'b0010);
    tick(12);
    bus.ch_mask = 4'b1111;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_valid(100, lat, ota_n);
    check("ign_latency", lat + 13, LAT);
    wait_done("ign_done_seen", 50);
    tick(40);
    check("ign_done_count", done_cnt - d0, 1);
    check("ign_q_empty", exp_q.size(), 0);

    // Empty mask
    d0 = done_cnt;
    bus.ch_mask = '0;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("empty_done", int'(bus.done), 1);
    check("empty_busy", int'(bus.busy), 0);
    check("empty_ota", int'(ota_en), 0);
    tick(1);
    check("empty_done_pulse", int'(bus.done), 0);
    tick(3);
    check("empty_busy_late", int'(bus.busy), 0);
    check("empty_done_count", done_cnt - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/digiota_scan_ctrl.md
Name: digiota_scan_ctrl

Overview:
Sequencer that time-shares one digital OTA/comparator across NCH input channel pairs. It selects each enabled channel in turn, enables the OTA, waits a settle window, and counts comparator-high samples over a fixed window. Each per-channel result is delivered over a valid/ready handshake. It sits between the OTA output pin and the digital readout logic and drives the analog mux select.

Parameters:
NCH, 4, number of channel pairs (2..16)
CH_W, 2, channel index width, equal to clog2(NCH)
SETTLE, 8, settle cycles after channel select (1..255)
NSAMP, 16, samples per conversion (1..255)
CNT_W, 5, result counter width, equal to clog2(NSAMP+1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin scan of channels in ch_mask; ignored unless IDLE
abort  in  1  synchronous abort; return to IDLE
ch_mask  in  NCH  enabled channels; sampled on accepted start
cmp_in  in  1  OTA/comparator output, asynchronous
ch_sel  out  CH_W  analog mux channel select
ota_en  out  1  OTA enable
busy  out  1  high in any state other than IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_ch  out  CH_W  channel of result
res_count  out  CNT_W  number of high samples
res_bit  out  1  majority decision: 2*res_count > NSAMP
done  out  1  one-cycle pulse at end of scan

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values: every output is 0, FSM is IDLE, and the internal mask, counters and sync flops are 0. Reset mid-operation aborts with no done pulse.
- Synchronizer: cmp_in passes through a 2-FF synchronizer. Accumulation uses the second stage only.
- FSM states: IDLE, SETTLE, SAMPLE, REPORT.
- IDLE:
  - ota_en=0, busy=0; ch_sel holds its last value.
  - On start with ch_mask!=0: latch ch_mask into scan_mask, set ch_sel to the lowest set bit, go to SETTLE with settle_cnt=SETTLE-1.
  - On start with ch_mask==0: pulse done on the next cycle and stay in IDLE.
- SETTLE:
  - ota_en=1.
  - Decrement settle_cnt. At 0, go to SAMPLE with acc=0 and samp_cnt=0.
  - The state lasts exactly SETTLE cycles.
- SAMPLE:
  - ota_en=1.
  - Each cycle, acc += sync_out. The state lasts exactly NSAMP cycles.
  - On the last cycle, load res_count with the final acc (including that cycle's sample), res_ch=ch_sel, res_bit=(2*final > NSAMP), set res_valid=1, go to REPORT.
- REPORT:
  - ota_en=0. res_valid and all res_* outputs are held stable until res_valid & res_ready.
  - On handshake: res_valid=0 and clear the ch_sel bit in scan_mask.
  - If remaining bits exist: ch_sel = lowest remaining bit, go to SETTLE.
  - Otherwise: go to IDLE and assert done for exactly one cycle, in the cycle after the handshake.
- Latency: res_valid is first visible SETTLE+NSAMP cycles after the edge that accepts start (24 with defaults). The next channel's SETTLE begins on the edge after the handshake.
- start while busy is ignored; ch_mask changes while busy have no effect.
- abort:
  - From any non-IDLE state, go to IDLE on the next edge: res_valid=0, ota_en=0, scan_mask cleared, no done.
  - abort has priority over start and over a handshake in the same cycle.
- Arithmetic: acc saturates by construction (at most NSAMP < 2^CNT_W). res_bit for an exact half is 0.
- Scan order is always ascending channel index.

Test Plan:
- Reset mid-op: start with mask=4'b0001, assert rst_n=0 for 2 cycles during SAMPLE -> all outputs 0, busy=0, no res_valid, no done; a fresh start then works normally.
- Single channel: mask=4'b0100, cmp_in=1 held, res_ready=1 -> ch_sel=2, ota_en high 24 cycles, res_valid at cycle 24 with res_ch=2, res_count=16, res_bit=1; done pulse in the cycle after the handshake.
- Multi-channel scan: mask=4'b1011, cmp_in=0 for ch0, toggling each cycle (after sync) for ch1, 1 for ch3 -> results in order ch0/0/0, ch1/8/0, ch3/16/1; exactly one done at the end.
- Backpressure: mask=4'b0011, res_ready=0 for 10 cycles after first res_valid -> res_valid and res_* held, ota_en=0, ch_sel stays 0 until the handshake; ch1 SETTLE starts on the following edge.
- Abort and ignored start: abort during SETTLE of ch0 -> IDLE next cycle, no res_valid, no done. start pulsed during SAMPLE -> no effect on mask or timing.
- Empty mask: start with ch_mask=0 -> done high exactly one cycle on the next edge; busy and ota_en never high.
